apb_slave_mem: RTL

APB completer with a small word-addressed register memory, sitting directly downstream of the APB master interface (`apb_vif`) driven by the AHB-to-APB bridge. It decodes SETUP/ACCESS phases, optionally inserts programmable wait states on `pready`, performs word writes and reads, and returns `prdata`. It is the reference target the bridge and the APB UVC master agent are exercised against.

---
 rtl/apb_slave_mem.sv | 133 +++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB completer over a DEPTH-word register memory; optional wait states when APB_SLV_WAIT_EN is defined.
// Latency: ACCESS lasts W+1 cycles (W = WAIT_CYCLES with APB_SLV_WAIT_EN, else 0); pready/prdata are registered.
// Backpressure: holds pready low for W ACCESS cycles; psel dropped mid-transfer aborts without writing.
module apb_slave_mem #(
  parameter int APB_DW      = 32,
  parameter int APB_AW      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  input  logic              pwrite,
  input  logic              psel,
  input  logic              penable,
  output logic              pready,
  output logic [APB_DW-1:0] prdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic              wr_q;
  logic [APB_DW-1:0] mem [DEPTH];
  logic              pready_q;
  logic [APB_DW-1:0] prdata_q;
  logic [APB_DW-1:0] prdata_d;
  logic [IW-1:0]     rd_idx;
  logic              rd_wr;
  logic              mem_we;
  logic              setup;

  assign setup = psel & ~penable;

  // Only the word-index bits of paddr matter; the rest alias.
  logic unused_addr;
  assign unused_addr = ^{paddr[APB_AW-1:IW+2], paddr[1:0]};

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = 4'd0;
    if (state_q == ST_IDLE && setup)
      cnt_d = WAIT_INIT;
    else if (state_q == ST_WAIT && psel)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 4'd0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (WAIT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
`ifdef APB_SLV_WAIT_EN
          state_d = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
`else
          state_d = ST_READY;
`endif
        end
      end
      ST_WAIT: begin
`ifdef APB_SLV_WAIT_EN
        if (!psel)              state_d = ST_IDLE;
        else if (cnt_q == 4'd1) state_d = ST_READY;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_READY: begin
        if (!psel || penable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // In IDLE the transfer is being set up this cycle, so decode straight from the bus.
  always_comb begin
    rd_idx   = (state_q == ST_IDLE) ? paddr[IW+1:2] : idx_q;
    rd_wr    = (state_q == ST_IDLE) ? pwrite : wr_q;
    prdata_d = '0;
    if (state_d == ST_READY && !rd_wr)
      prdata_d = mem[rd_idx];
    mem_we = (state_q == ST_READY) && psel && penable && wr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      wr_q     <= 1'b0;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && setup) begin
        idx_q <= paddr[IW+1:2];
        wr_q  <= pwrite;
      end
      pready_q <= (state_d == ST_READY);
      prdata_q <= prdata_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[idx_q] <= pwdata;
    end
  end

  assign pready = pready_q;
  assign prdata = prdata_q;

endmodule
